fetch_redirect_ctrl: RTL

//  Owns the fetch PC register and decides the next fetch PC every cycle.

---
 rtl/fetch_redirect_ctrl_if.sv | 39 +++
 rtl/fetch_redirect_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch redirect bundle: stall and redirect requests toward the PC owner, and the fetch PC and flush/forward status back.
// Latency and backpressure are set by the controller; this file only groups the wires and gives each side its direction.
interface fetch_redirect_ctrl_if #(
    parameter int PERF_W = 32
);
    logic              fetch_ready;
    logic              eret_req;
    logic [31:0]       epc;
    logic              exc_req;
    logic [31:0]       exc_entrance;
    logic              icache_req;
    logic [31:0]       icache_addr;
    logic              br_req;
    logic [31:0]       br_target;
    logic              replay_req;
    logic              pred_taken;
    logic [31:0]       pred_pc;
    logic [31:0]       pc;
    logic              flush_fetch;
    logic [1:0]        forward_pc_type;
    logic              pend_busy;
    logic              pc_misalign;
    logic [PERF_W-1:0] perf_redirects;
    logic [PERF_W-1:0] perf_pend_cyc;

    modport master (
        output fetch_ready, eret_req, epc, exc_req, exc_entrance, icache_req, icache_addr,
               br_req, br_target, replay_req, pred_taken, pred_pc,
        input  pc, flush_fetch, forward_pc_type, pend_busy, pc_misalign,
               perf_redirects, perf_pend_cyc
    );

    modport slave (
        input  fetch_ready, eret_req, epc, exc_req, exc_entrance, icache_req, icache_addr,
               br_req, br_target, replay_req, pred_taken, pred_pc,
        output pc, flush_fetch, forward_pc_type, pend_busy, pc_misalign,
               perf_redirects, perf_pend_cyc
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: picks next pc by priority (pc visible next cycle); flush-class redirects seen while stalled are held in PEND.
// Optional saturating perf counters are built only when REDIRECT_PERF_EN is defined.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter int          PERF_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_redirect_ctrl_if.slave  bus
);
    localparam logic [1:0] NO_FORWARD = 2'd0;
    localparam logic [1:0] PCM        = 2'd1;
    localparam logic [1:0] PCW        = 2'd2;

    // Higher value wins; zero means no flush-class request.
    localparam logic [2:0] PRI_NONE   = 3'd0;
    localparam logic [2:0] PRI_BR     = 3'd1;
    localparam logic [2:0] PRI_ICACHE = 3'd2;
    localparam logic [2:0] PRI_EXC    = 3'd3;
    localparam logic [2:0] PRI_ERET   = 3'd4;

    typedef enum logic {S_RUN, S_PEND} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pc_misalign_q, pc_misalign_d;
    logic [2:0]  held_pri_q, held_pri_d;
    logic [31:0] held_tgt_q, held_tgt_d;

    logic [2:0]  live_pri;
    logic [31:0] live_tgt;
    logic        live_wins;
    logic [2:0]  sel_pri;
    logic [31:0] sel_tgt;
    logic        apply;

    always_comb begin
        live_pri = PRI_NONE;
        live_tgt = '0;
        if (bus.eret_req) begin
            live_pri = PRI_ERET;
            live_tgt = bus.epc;
        end else if (bus.exc_req) begin
            live_pri = PRI_EXC;
            live_tgt = bus.exc_entrance;
        end else if (bus.icache_req) begin
            live_pri = PRI_ICACHE;
            live_tgt = bus.icache_addr;
        end else if (bus.br_req) begin
            live_pri = PRI_BR;
            live_tgt = bus.br_target;
        end
    end

    // held_pri_q is cleared whenever we leave PEND, so in RUN the live request always wins.
    assign live_wins = (live_pri > held_pri_q);
    assign sel_pri   = live_wins ? live_pri : held_pri_q;
    assign sel_tgt   = live_wins ? live_tgt : held_tgt_q;
    assign apply     = bus.fetch_ready && (sel_pri != PRI_NONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            pc_misalign_q <= 1'b0;
            held_pri_q    <= PRI_NONE;
            held_tgt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_misalign_q <= pc_misalign_d;
            held_pri_q    <= held_pri_d;
            held_tgt_q    <= held_tgt_d;
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (!bus.fetch_ready && (live_pri != PRI_NONE)) state_d = S_PEND;
            S_PEND:  if (bus.fetch_ready) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Next pc and held redirect
    always_comb begin
        pc_d       = pc_q;
        held_pri_d = held_pri_q;
        held_tgt_d = held_tgt_q;
        if (bus.fetch_ready) begin
            held_pri_d = PRI_NONE;
            held_tgt_d = '0;
            if (sel_pri != PRI_NONE) begin
                pc_d = sel_tgt;
            end else if (bus.replay_req) begin
                pc_d = pc_q;
            end else if (bus.pred_taken) begin
                pc_d = bus.pred_pc;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end else if (live_wins) begin
            held_pri_d = live_pri;
            held_tgt_d = live_tgt;
        end
        pc_misalign_d = |pc_d[1:0];
    end

    // Outputs
    always_comb begin
        bus.pc              = pc_q;
        bus.pc_misalign     = pc_misalign_q;
        bus.flush_fetch     = 1'b0;
        bus.pend_busy       = 1'b0;
        bus.forward_pc_type = NO_FORWARD;
        if (!reset) begin
            bus.flush_fetch = (live_pri != PRI_NONE) || (state_q == S_PEND);
            bus.pend_busy   = (state_q == S_PEND) || (!bus.fetch_ready && (live_pri != PRI_NONE));
            if (apply) begin
                bus.forward_pc_type = (sel_pri >= PRI_EXC) ? PCW : PCM;
            end
        end
    end

`ifdef REDIRECT_PERF_EN
    logic [PERF_W-1:0] perf_redir_q, perf_redir_d;
    logic [PERF_W-1:0] perf_pend_q, perf_pend_d;

    always_comb begin
        perf_redir_d = perf_redir_q;
        perf_pend_d  = perf_pend_q;
        if (apply && !(&perf_redir_q)) perf_redir_d = perf_redir_q + PERF_W'(1);
        if ((state_q == S_PEND) && !(&perf_pend_q)) perf_pend_d = perf_pend_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_redir_q <= '0;
            perf_pend_q  <= '0;
        end else begin
            perf_redir_q <= perf_redir_d;
            perf_pend_q  <= perf_pend_d;
        end
    end

    assign bus.perf_redirects = perf_redir_q;
    assign bus.perf_pend_cyc  = perf_pend_q;
`else
    assign bus.perf_redirects = {PERF_W{1'b0}};
    assign bus.perf_pend_cyc  = {PERF_W{1'b0}};
`endif
endmodule
